// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, lap entry layout and width helper for the lap timer.
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSED = 2'd2} sw_state_t;
   localparam int LAP_CH_W   = 2;
   localparam int LAP_DATA_W = 16;
   typedef struct packed {
      logic [LAP_CH_W-1:0]   ch;
      logic [LAP_DATA_W-1:0] data;
   } lap_entry_t;
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/stopwatch_lap_timer_channel.sv
// stopwatch_channel: one stopwatch channel holding its FSM, elapsed count and lap snapshot.
// STOPWATCH_WRAP_EN makes the count wrap to zero at the limit instead of saturating.
module stopwatch_channel
   import stopwatch_pkg::*;
#(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset_tb,
   input  logic                  tick,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  clear,
   input  logic                  lap,
   input  logic                  grant,
   output logic [DATA_WIDTH-1:0] count,
   output logic [DATA_WIDTH-1:0] snap,
   output logic                  running,
   output logic                  overflow,
   output logic                  pending,
   output logic                  drop
);
   sw_state_t             state_q, state_d;
   logic [DATA_WIDTH-1:0] count_q, count_d, snap_q, snap_d;
   logic                  overflow_q, overflow_d, pending_q, pending_d, drop_q, drop_d;
   logic                  inc, lap_ok;
   always_comb begin
      inc        = (state_q == RUN) && tick;
      lap_ok     = lap && !clear;
      state_d    = clear ? IDLE : stop ? ((state_q == RUN) ? PAUSED : state_q) : start ? RUN : state_q;
`ifdef STOPWATCH_WRAP_EN
      count_d    = clear ? '0 : inc ? count_q + DATA_WIDTH'(1) : count_q;
`else
      count_d    = clear ? '0 : (inc && !(&count_q)) ? count_q + DATA_WIDTH'(1) : count_q;
`endif
      overflow_d = !clear && (overflow_q || (inc && (&count_q)));
      snap_d     = lap_ok ? count_q : snap_q;
      // a snapshot taken in the same cycle the old one is pushed is not a loss
      pending_d  = !clear && (lap_ok || (pending_q && !grant));
      drop_d     = lap_ok && pending_q && !grant;
   end
   always_ff @(posedge clk or negedge reset_tb) begin
      if (!reset_tb) begin
         state_q    <= IDLE;
         count_q    <= '0;
         snap_q     <= '0;
         overflow_q <= 1'b0;
         pending_q  <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         snap_q     <= snap_d;
         overflow_q <= overflow_d;
         pending_q  <= pending_d;
         drop_q     <= drop_d;
      end
   end
   assign count    = count_q;
   assign snap     = snap_q;
   assign running  = state_q == RUN;
   assign overflow = overflow_q;
   assign pending  = pending_q;
   assign drop     = drop_q;
endmodule

// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: multi-channel stopwatch with shared prescaler and arbitrated lap FIFO.
// STOPWATCH_WRAP_EN (passed to the channels) selects wrap instead of saturation at the count limit.
module stopwatch_lap_timer
   import stopwatch_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_CH     = 4,
   parameter int PRESCALE   = 1,
   parameter int LAP_DEPTH  = 8
) (
   input  logic                           clk,
   input  logic                           reset_tb,
   input  logic [NUM_CH-1:0]              start,
   input  logic [NUM_CH-1:0]              stop,
   input  logic [NUM_CH-1:0]              clear,
   input  logic [NUM_CH-1:0]              lap,
   output logic [NUM_CH*DATA_WIDTH-1:0]   count,
   output logic [NUM_CH-1:0]              running,
   output logic [NUM_CH-1:0]              overflow,
   output logic                           lap_valid,
   input  logic                           lap_ready,
   output logic [clog2_min1(NUM_CH)-1:0]  lap_ch,
   output logic [DATA_WIDTH-1:0]          lap_data,
   output logic                           lap_drop
);
   localparam int CH_W = clog2_min1(NUM_CH);
   localparam int PS_W = clog2_min1(PRESCALE);
   localparam int AW   = $clog2(LAP_DEPTH);
   typedef struct packed {
      logic [CH_W-1:0]       ch;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;
   logic [PS_W-1:0]       presc_q, presc_d;
   logic [AW:0]           wr_q, wr_d, rd_q, rd_d;
   entry_t                mem_q [LAP_DEPTH];
   logic [DATA_WIDTH-1:0] snap [NUM_CH];
   logic [NUM_CH-1:0]     pending, drop, req, grant;
   logic [CH_W-1:0]       sel;
   logic                  tick, full, empty, push, pop;
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      stopwatch_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
         .clk      (clk),
         .reset_tb (reset_tb),
         .tick     (tick),
         .start    (start[i]),
         .stop     (stop[i]),
         .clear    (clear[i]),
         .lap      (lap[i]),
         .grant    (grant[i]),
         .count    (count[i*DATA_WIDTH +: DATA_WIDTH]),
         .snap     (snap[i]),
         .running  (running[i]),
         .overflow (overflow[i]),
         .pending  (pending[i]),
         .drop     (drop[i])
      );
   end
   always_comb begin
      tick    = presc_q == PS_W'(PRESCALE - 1);
      presc_d = tick ? '0 : presc_q + PS_W'(1);
      // a channel being cleared this cycle loses its pending lap instead of pushing it
      req     = pending & ~clear;
      sel     = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (req[i]) sel = CH_W'(i);
      empty   = wr_q == rd_q;
      full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
      pop     = !empty && lap_ready;
      push    = (|req) && (!full || pop);
      grant   = push ? (NUM_CH'(1) << sel) : '0;
      wr_d    = wr_q + {{AW{1'b0}}, push};
      rd_d    = rd_q + {{AW{1'b0}}, pop};
   end
   always_ff @(posedge clk or negedge reset_tb) begin
      if (!reset_tb) begin
         presc_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
      end else begin
         presc_q <= presc_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= '{ch: sel, data: snap[sel]};
   end
   assign lap_valid = !empty;
   assign lap_ch    = empty ? '0 : mem_q[rd_q[AW-1:0]].ch;
   assign lap_data  = empty ? '0 : mem_q[rd_q[AW-1:0]].data;
   assign lap_drop  = |drop;
endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// tb_stopwatch_lap_timer: directed checks of the lap timer in a default and a small-width/prescaled build.
module tb_stopwatch_lap_timer;
   logic        clk = 1'b0, reset_tb = 1'b0;
   logic [3:0]  start = '0, stop = '0, clear = '0, lap = '0;
   logic        lap_ready = 1'b0;
   logic [63:0] count;
   logic [3:0]  running, overflow;
   logic        lap_valid, lap_drop;
   logic [1:0]  lap_ch;
   logic [15:0] lap_data;
   logic [1:0]  v_start = '0, v_stop = '0, v_clear = '0, v_lap = '0;
   logic        v_lap_ready = 1'b0;
   logic [7:0]  v_count;
   logic [1:0]  v_running, v_overflow;
   logic        v_lap_valid, v_lap_drop;
   logic [0:0]  v_lap_ch;
   logic [3:0]  v_lap_data;
   int          errors = 0, checks = 0;
   always #5 clk = ~clk;
   stopwatch_lap_timer u_dut (
      .clk(clk), .reset_tb(reset_tb), .start(start), .stop(stop), .clear(clear), .lap(lap),
      .count(count), .running(running), .overflow(overflow), .lap_valid(lap_valid),
      .lap_ready(lap_ready), .lap_ch(lap_ch), .lap_data(lap_data), .lap_drop(lap_drop)
   );
   stopwatch_lap_timer #(.DATA_WIDTH(4), .NUM_CH(2), .PRESCALE(4), .LAP_DEPTH(2)) u_small (
      .clk(clk), .reset_tb(reset_tb), .start(v_start), .stop(v_stop), .clear(v_clear), .lap(v_lap),
      .count(v_count), .running(v_running), .overflow(v_overflow), .lap_valid(v_lap_valid),
      .lap_ready(v_lap_ready), .lap_ch(v_lap_ch), .lap_data(v_lap_data), .lap_drop(v_lap_drop)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   function automatic logic [31:0] cnt(input int i);
      return 32'(count[i*16 +: 16]);
   endfunction
   initial begin
      #2;
      chk("rst_count", 32'(|count), 0);
      chk("rst_running", 32'(running), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_lap_valid", 32'(lap_valid), 0);
      chk("rst_lap_out", {14'd0, lap_ch, lap_data}, 0);
      chk("rst_lap_drop", 32'(lap_drop), 0);
      #10 reset_tb = 1'b1;
      step(1);
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      chk("run_after_start", 32'(running[0]), 1);
      chk("cnt_after_start", cnt(0), 0);
      step(1);
      chk("cnt_first_inc", cnt(0), 1);
      step(7);
      stop[0] = 1'b1; step(1); stop[0] = 1'b0;
      chk("cnt_at_stop", cnt(0), 9);
      chk("run_after_stop", 32'(running[0]), 0);
      step(3);
      chk("cnt_frozen", cnt(0), 9);
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      chk("resume_run", 32'(running[0]), 1);
      chk("resume_hold", cnt(0), 9);
      step(2);
      chk("resume_inc", cnt(0), 11);
      chk("ch1_idle", cnt(1), 0);
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      chk("start_while_run", cnt(0), 12);
      clear[1:0] = 2'b11; stop[0] = 1'b1; start[1] = 1'b1; step(1);
      clear = '0; stop = '0; start = '0;
      chk("clear_cnt", cnt(0), 0);
      chk("clear_prio", 32'(running[1:0]), 0);
      chk("clear_ch1_cnt", cnt(1), 0);
      start[2] = 1'b1; step(1); start[2] = 1'b0;
      step(1);
      start[0] = 1'b1; step(1); start[0] = 1'b0;
      step(5);
      chk("pre_lap_c0", cnt(0), 5);
      chk("pre_lap_c2", cnt(2), 7);
      lap_ready = 1'b1; lap[0] = 1'b1; lap[2] = 1'b1; stop[0] = 1'b1; stop[2] = 1'b1; step(1);
      lap = '0; stop = '0;
      chk("lap_valid_n1", 32'(lap_valid), 0);
      chk("stop_c0", cnt(0), 6);
      step(1);
      chk("lap0_valid", 32'(lap_valid), 1);
      chk("lap0_ch", 32'(lap_ch), 0);
      chk("lap0_data", 32'(lap_data), 5);
      chk("lap0_drop", 32'(lap_drop), 0);
      step(1);
      chk("lap1_valid", 32'(lap_valid), 1);
      chk("lap1_ch", 32'(lap_ch), 2);
      chk("lap1_data", 32'(lap_data), 7);
      chk("lap1_drop", 32'(lap_drop), 0);
      step(1);
      chk("lap_empty", 32'(lap_valid), 0);
      lap_ready = 1'b0;
      start[3] = 1'b1; step(1); start[3] = 1'b0;
      for (int i = 0; i < 9; i++) begin
         lap[3] = 1'b1; step(1); lap[3] = 1'b0; step(1);
      end
      chk("full_valid", 32'(lap_valid), 1);
      chk("full_head_ch", 32'(lap_ch), 3);
      chk("full_head_data", 32'(lap_data), 0);
      chk("full_no_drop", 32'(lap_drop), 0);
      lap[3] = 1'b1; step(1); lap[3] = 1'b0;
      chk("drop_pulse", 32'(lap_drop), 1);
      step(1);
      chk("drop_one_cycle", 32'(lap_drop), 0);
      lap_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("drain%0d_valid", i), 32'(lap_valid), 1);
         chk($sformatf("drain%0d_ch", i), 32'(lap_ch), 3);
         chk($sformatf("drain%0d_data", i), 32'(lap_data), (i < 8) ? 32'(2 * i) : 32'd18);
         step(1);
      end
      chk("drain_empty", 32'(lap_valid), 0);
      v_start[0] = 1'b1; step(1); v_start[0] = 1'b0;
      step(40);
      chk("ps_cnt", 32'(v_count[3:0]), 10);
      chk("ps_ch1", 32'(v_count[7:4]), 0);
      step(40);
`ifdef STOPWATCH_WRAP_EN
      chk("limit_cnt", 32'(v_count[3:0]), 4);
`else
      chk("limit_cnt", 32'(v_count[3:0]), 15);
`endif
      chk("limit_ovf", 32'(v_overflow[0]), 1);
      chk("limit_run", 32'(v_running[0]), 1);
      v_clear[0] = 1'b1; step(1); v_clear[0] = 1'b0;
      chk("vclr_cnt", 32'(v_count[3:0]), 0);
      chk("vclr_ovf", 32'(v_overflow[0]), 0);
      chk("vclr_run", 32'(v_running[0]), 0);
      lap_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         lap[3] = 1'b1; step(1); lap[3] = 1'b0; step(1);
      end
      chk("pre_rst_valid", 32'(lap_valid), 1);
      chk("pre_rst_run", 32'(running[3]), 1);
      #2 reset_tb = 1'b0;
      #1;
      chk("async_count", 32'(|count), 0);
      chk("async_running", 32'(running), 0);
      chk("async_lap_valid", 32'(lap_valid), 0);
      chk("async_lap_out", {14'd0, lap_ch, lap_data}, 0);
      chk("async_small", {19'd0, v_count, v_lap_valid, v_lap_drop, v_lap_ch, v_lap_data}, 0);
      #3 reset_tb = 1'b1;
      step(1);
      chk("post_rst_valid", 32'(lap_valid), 0);
      chk("post_rst_running", 32'(running), 0);
      chk("post_rst_count", 32'(|count), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
